arb_req_client: RTL and testbench
=================================

# arb_req_client

Requester-side agent for the team's two-tier arbiter: it sits between a local command source and one request slot of the arbiter, queues burst commands, drives `request`/`lock`/`prior` toward the arbiter, and consumes that slot's `grant` bit. It counts granted beats, holds `lock` through multi-beat bursts, and raises its priority while starved. One instance is placed per arbiter client.

## Interface
- `depth`, 4: command FIFO entries (2..16).
- `len_width`, 4: width of the burst-length field; a burst is `len+1` beats.
- `p_width`, 2: width of the `prior` output; must match the arbiter's `p_width`.
- `base_prior`, 0: `prior` value at reset and at the start of every request.
- `age_limit`, 8: ungranted REQ cycles per priority step (1..255).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_len`  in  len_width  beats minus one.
- `request`  out  1  to arbiter `request[i]`.
- `lock`  out  1  to arbiter `lock[i]`.
- `prior`  out  p_width  to arbiter `prior` slice i.
- `grant`  in  1  arbiter `grant[i]`.
- `beat_valid`  out  1  a beat transfers this cycle.
- `beat_last`  out  1  final beat of the head burst.
- `beat_cnt`  out  len_width  index of the current beat within the burst.

## Operation
- FIFO: push when `cmd_valid & cmd_ready`. `cmd_ready = (count != depth)` is computed from the registered count only. A push is refused when full, even in a cycle with a pop. Pop occurs on the `beat_last` cycle. Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo `depth`.
- FSM states are IDLE, REQ and XFER.
  - IDLE: `request=0`, `lock=0`, `prior=base_prior`. Moves to REQ when `count!=0`.
  - REQ: `request=1`, `lock=0`.
    - `grant=1` is beat 0.
    - If `head_len==0`, that beat is last: pop, then go to IDLE.
    - Otherwise go to XFER with `beat_cnt=1`.
  - XFER: `request=1`, `lock=1`.
    - Each `grant=1` cycle is a beat and increments `beat_cnt`.
    - A `grant=0` cycle stalls with no beat and no counter change. The state stays XFER and `lock` stays high.
    - The beat with `beat_cnt==head_len` is last: pop, go to IDLE, clear `beat_cnt` to 0.
- The FSM always returns to IDLE for one cycle after a burst, even with the FIFO non-empty. This guarantees other clients an arbitration opening.
- `beat_valid = request & grant` (combinational).
- `beat_last = beat_valid & (beat_cnt == head_len)`.
- Aging (REQ state only):
  - `wait_cnt` increments on every `grant=0` cycle.
  - On reaching `age_limit-1` it clears and `prior` increments, saturating at `2^p_width-1`.
  - `wait_cnt` and `prior` hold in XFER.
  - Both return to 0/`base_prior` in IDLE.
- Arithmetic: `beat_cnt` is `len_width` bits and never wraps, because it stops at `head_len`. `count` is `clog2(depth+1)` bits.

## Timing
- Reset (`rst_n` low at a rising edge) produces, from the next cycle:
  - state IDLE, FIFO empty;
  - `request=0`, `lock=0`, `prior=base_prior`;
  - `beat_valid=0`, `beat_last=0`, `beat_cnt=0`, `cmd_ready=1`.
- Pushes are ignored while `rst_n` is low.
- Reset mid-burst discards all queued commands and drops `request`/`lock` in the next cycle.
- Latency: a push at edge t gives `count!=0` at t+1 and REQ (with `request=1`) at t+2. The earliest beat is at t+2 if `grant` is already high.
- `request`, `lock` and `prior` are registered (Moore). `beat_valid`/`beat_last` are combinational from `grant`.
- `grant` is sampled only in REQ/XFER; a `grant` in IDLE is ignored and produces no beat.
- Back-to-back bursts have a minimum gap of one IDLE cycle between the last beat and the next `request`.

## Test plan
- Single beat, `len=0`, `grant` tied 1: push at cycle 0 gives `request=1` at cycle 2, with `beat_valid=beat_last=1` that same cycle. IDLE follows at cycle 3, `lock` is never high, and `count` returns to 0.
- Burst with stalls, `len=3`, grant pattern 1,0,1,1,0,1 from REQ: 4 beats with `beat_cnt` 0,1,2,3 and `lock=1` through all XFER cycles including stalls. `beat_last` falls on the sixth grant cycle; `lock=0` and `request=0` the cycle after.
- FIFO full, `depth=4`, `grant=0`: 4 pushes accepted, `cmd_ready=0`, 5th refused. A pop cycle with `cmd_valid=1` still refuses the push; `cmd_ready=1` the next cycle.
- Aging, `age_limit=8`, `p_width=2`, `grant=0` for 40 REQ cycles: `prior` steps 0→1→2→3 at cycles 8, 16, 24 of REQ and stays 3. After the burst completes, IDLE shows `prior=0`.
- Two queued commands (`len=1`, `len=0`), `grant=1`: beats at cycles 2, 3, then IDLE at 4, then REQ+beat at 5. Exactly one IDLE gap between bursts.
- Reset during XFER of a `len=7` burst after 3 beats: the next cycle shows `request=0`, `lock=0`, `beat_cnt=0` and an empty FIFO, and a stale `grant=1` produces no beat.

Source files
------------

// File: rtl/arb_req_client_if.sv
// Handshake bundle between a command source, one arbiter request slot, and arb_req_client.
// The master modport is the client agent; the slave modport is the source/arbiter side.
interface arb_req_client_if #(
  parameter int len_width = 4,
  parameter int p_width   = 2
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [len_width-1:0] cmd_len;
  logic                 request;
  logic                 lock;
  logic [p_width-1:0]   prior;
  logic                 grant;
  logic                 beat_valid;
  logic                 beat_last;
  logic [len_width-1:0] beat_cnt;

  modport master (
    input  cmd_valid, cmd_len, grant,
    output cmd_ready, request, lock, prior, beat_valid, beat_last, beat_cnt
  );

  modport slave (
    output cmd_valid, cmd_len, grant,
    input  cmd_ready, request, lock, prior, beat_valid, beat_last, beat_cnt
  );
endinterface

// File: rtl/arb_req_client.sv
// Requester-side arbiter agent: queues burst commands, requests/locks its arbiter slot,
// counts granted beats and ages its priority while waiting for the first grant.
module arb_req_client #(
  parameter int depth      = 4,
  parameter int len_width  = 4,
  parameter int p_width    = 2,
  parameter int base_prior = 0,
  parameter int age_limit  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  arb_req_client_if.master   bus
);
  localparam int cnt_w = $clog2(depth + 1);
  localparam int ptr_w = $clog2(depth);
  localparam logic [cnt_w-1:0]   depth_c    = cnt_w'(depth);
  localparam logic [ptr_w-1:0]   last_ptr   = ptr_w'(depth - 1);
  localparam logic [p_width-1:0] prior_base = p_width'(base_prior);
  localparam logic [p_width-1:0] prior_max  = '1;
  localparam logic [7:0]         wait_top   = 8'(age_limit - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t               state, next_state;
  logic [len_width-1:0] mem [depth];
  logic [ptr_w-1:0]     wr_ptr, rd_ptr;
  logic [cnt_w-1:0]     count;
  logic [len_width-1:0] head_len;
  logic [len_width-1:0] beat_cnt;
  logic [7:0]           wait_cnt;
  logic [p_width-1:0]   prior;
  logic                 push, pop, beat, last;

  assign head_len       = mem[rd_ptr];
  assign bus.cmd_ready  = (count != depth_c);
  assign push           = bus.cmd_valid & bus.cmd_ready;
  assign bus.request    = (state != IDLE);
  assign bus.lock       = (state == XFER);
  assign beat           = bus.request & bus.grant;
  assign last           = beat & (beat_cnt == head_len);
  assign pop            = last;
  assign bus.beat_valid = beat;
  assign bus.beat_last  = last;
  assign bus.beat_cnt   = beat_cnt;
  assign bus.prior      = prior;

  // NOTE: the command storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= bus.cmd_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (count != '0) next_state = REQ;
      REQ: begin
        if (last)           next_state = IDLE;
        else if (bus.grant) next_state = XFER;
      end
      XFER:    if (last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Priority ages only while waiting for the first grant; every return to IDLE restores it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      wait_cnt <= '0;
      prior    <= prior_base;
    end else begin
      state <= next_state;
      if (last)      beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (next_state == IDLE) begin
        wait_cnt <= '0;
        prior    <= prior_base;
      end else if (state == REQ && !bus.grant) begin
        if (wait_cnt == wait_top) begin
          wait_cnt <= '0;
          if (prior != prior_max) prior <= prior + 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_arb_req_client.sv
// Self-checking bench for arb_req_client: directed scenarios plus randomized traffic,
// compared against a queue-based behavioural model of the client.
module tb_arb_req_client;
  localparam int depth      = 4;
  localparam int len_width  = 4;
  localparam int p_width    = 2;
  localparam int base_prior = 0;
  localparam int age_limit  = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  arb_req_client_if #(.len_width(len_width), .p_width(p_width)) bus ();

  arb_req_client #(
    .depth(depth), .len_width(len_width), .p_width(p_width),
    .base_prior(base_prior), .age_limit(age_limit)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: queued lengths, whether a burst is active, beats granted so far,
  // and ungranted cycles spent waiting for the first beat.
  logic [len_width-1:0] m_q [$];
  bit                   m_busy;
  int                   m_beats;
  int                   m_waits;

  function automatic logic [10:0] model_out();
    logic rdy, req, lk, bv, bl;
    logic [p_width-1:0]   pr;
    logic [len_width-1:0] bc;
    int p;
    rdy = (m_q.size() != depth);
    req = m_busy;
    lk  = m_busy && (m_beats > 0);
    p   = base_prior + m_waits / age_limit;
    if (p > (1 << p_width) - 1) p = (1 << p_width) - 1;
    pr  = m_busy ? p_width'(p) : p_width'(base_prior);
    bv  = m_busy && (bus.grant === 1'b1);
    bl  = bv && (m_beats == int'(m_q[0]));
    bc  = len_width'(m_beats);
    return {rdy, req, lk, pr, bv, bl, bc};
  endfunction

  function automatic logic [10:0] get_obs();
    return {bus.cmd_ready, bus.request, bus.lock, bus.prior,
            bus.beat_valid, bus.beat_last, bus.beat_cnt};
  endfunction

  task automatic model_step();
    int sz;
    bit rdy;
    if (!rst_n) begin
      m_q.delete();
      m_busy  = 0;
      m_beats = 0;
      m_waits = 0;
      return;
    end
    sz  = m_q.size();
    rdy = (sz != depth);
    if (m_busy) begin
      if (bus.grant) begin
        if (m_beats == int'(m_q[0])) begin
          void'(m_q.pop_front());
          m_busy  = 0;
          m_beats = 0;
          m_waits = 0;
        end else begin
          m_beats++;
        end
      end else if (m_beats == 0) begin
        m_waits++;
      end
    end else if (sz != 0) begin
      m_busy = 1;
    end
    if (bus.cmd_valid && rdy) m_q.push_back(bus.cmd_len);
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.grant     = 1'b0;
    end_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] obs, exp;
    rst_n = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_len = 4'd5; bus.grant = 1'b1;
    repeat (2) end_cycle();
    rst_n = 1'b1; bus.cmd_valid = 1'b0; bus.grant = 1'b0;
    @(negedge clk);
    checks++;
    if (get_obs() !== 11'b1_0_0_00_0_0_0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", get_obs(), 11'b1_0_0_00_0_0_0000);
    end
    end_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_no_push c=%0d: got %b expected %b", c, obs, exp);
      end
      end_cycle();
    end
  endtask

  task automatic test_single_beat();
    logic [10:0] obs, exp;
    bit saw_lock = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.cmd_valid = (c == 0); bus.cmd_len = '0; bus.grant = 1'b1;
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_beat c=%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 2) begin
        checks++;
        if ({bus.request, bus.beat_valid, bus.beat_last} !== 3'b111) begin
          errors++;
          $display("FAIL single_beat_c2: got req/bv/bl=%b expected 111",
                   {bus.request, bus.beat_valid, bus.beat_last});
        end
      end
      if (c == 3) begin
        checks++;
        if (bus.request !== 1'b0) begin
          errors++;
          $display("FAIL single_beat_idle: got request=%b expected 0", bus.request);
        end
      end
      if (bus.lock === 1'b1) saw_lock = 1;
      end_cycle();
    end
    checks++;
    if (saw_lock !== 1'b0) begin
      errors++;
      $display("FAIL single_beat_lock: got lock seen=%b expected 0", saw_lock);
    end
  endtask

  task automatic test_burst_stalls();
    logic [10:0] obs, exp;
    bit g [10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0};
    int beats [$];
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.cmd_valid = (c == 0); bus.cmd_len = 4'd3; bus.grant = g[c];
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL burst_stalls c=%0d: got %b expected %b", c, obs, exp);
      end
      checks++;
      if ({bus.lock, bus.beat_last} !== {1'(c >= 3 && c <= 7), 1'(c == 7)}) begin
        errors++;
        $display("FAIL burst_lock_last c=%0d: got lock/last=%b expected %b", c,
                 {bus.lock, bus.beat_last}, {1'(c >= 3 && c <= 7), 1'(c == 7)});
      end
      if (bus.beat_valid === 1'b1) beats.push_back(int'(bus.beat_cnt));
      end_cycle();
    end
    checks++;
    if (beats.size() != 4) begin
      errors++;
      $display("FAIL burst_beat_count: got %0d expected 4", beats.size());
    end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      checks++;
      if (beats[i] != i) begin
        errors++;
        $display("FAIL burst_beat_cnt i=%0d: got %0d expected %0d", i, beats[i], i);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [10:0] obs, exp;
    int nbeats = 0;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      bus.cmd_valid = (c <= 6); bus.cmd_len = '0; bus.grant = (c >= 6);
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fifo_full c=%0d: got %b expected %b", c, obs, exp);
      end
      if (c >= 4 && c <= 7) begin
        checks++;
        if (bus.cmd_ready !== 1'(c == 7)) begin
          errors++;
          $display("FAIL fifo_ready c=%0d: got %b expected %b", c, bus.cmd_ready, 1'(c == 7));
        end
      end
      if (bus.beat_valid === 1'b1) nbeats++;
      end_cycle();
    end
    checks++;
    if (nbeats != 4) begin
      errors++;
      $display("FAIL fifo_accepted: got %0d bursts expected 4", nbeats);
    end
  endtask

  task automatic test_aging();
    logic [10:0] obs, exp;
    int rs [7] = '{7, 8, 15, 16, 23, 24, 39};
    int ps [7] = '{0, 1, 1, 2, 2, 3, 3};
    do_reset();
    for (int c = 0; c < 46; c++) begin
      bus.cmd_valid = (c == 0); bus.cmd_len = 4'd1; bus.grant = (c == 42 || c == 43);
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL aging c=%0d: got %b expected %b", c, obs, exp);
      end
      for (int i = 0; i < 7; i++) begin
        if (c - 2 == rs[i]) begin
          checks++;
          if (int'(bus.prior) != ps[i]) begin
            errors++;
            $display("FAIL aging_prior r=%0d: got %0d expected %0d", rs[i], bus.prior, ps[i]);
          end
        end
      end
      if (c == 43 || c == 44) begin
        checks++;
        if (int'(bus.prior) != ((c == 43) ? 3 : base_prior)) begin
          errors++;
          $display("FAIL aging_after c=%0d: got %0d expected %0d", c, bus.prior,
                   (c == 43) ? 3 : base_prior);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs, exp;
    bit bv [8] = '{0, 0, 1, 1, 0, 1, 0, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.cmd_valid = (c <= 1); bus.cmd_len = (c == 0) ? 4'd1 : 4'd0; bus.grant = 1'b1;
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d: got %b expected %b", c, obs, exp);
      end
      checks++;
      if (bus.beat_valid !== bv[c]) begin
        errors++;
        $display("FAIL b2b_beat c=%0d: got %b expected %b", c, bus.beat_valid, bv[c]);
      end
      end_cycle();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [10:0] obs, exp;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.cmd_valid = (c <= 1); bus.cmd_len = (c == 0) ? 4'd7 : 4'd2; bus.grant = 1'b1;
      rst_n = (c != 5);
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid c=%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 5) begin
        checks++;
        if (bus.beat_cnt !== 4'd3) begin
          errors++;
          $display("FAIL reset_mid_cnt: got %0d expected 3", bus.beat_cnt);
        end
      end
      if (c >= 6) begin
        checks++;
        if ({bus.request, bus.lock, bus.beat_valid, bus.beat_cnt} !== 7'b0) begin
          errors++;
          $display("FAIL reset_mid_clear c=%0d: got %b expected 0", c,
                   {bus.request, bus.lock, bus.beat_valid, bus.beat_cnt});
        end
      end
      end_cycle();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [10:0] obs, exp;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      bus.cmd_valid = ($urandom_range(0, 99) < 40);
      bus.cmd_len   = len_width'($urandom_range(0, (1 << len_width) - 1));
      bus.grant     = ($urandom_range(0, 99) < 55);
      rst_n         = ($urandom_range(0, 149) != 0);
      @(negedge clk);
      obs = get_obs(); exp = model_out();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random c=%0d: got %b expected %b", c, obs, exp);
      end
      end_cycle();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.grant = 1'b0;
    m_busy = 0; m_beats = 0; m_waits = 0;
    test_reset();
    test_single_beat();
    test_burst_stalls();
    test_fifo_full();
    test_aging();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
